// File: rtl/dram_write_engine.sv
// dram_write_engine: buffers write commands and data, then issues one AXI4 INCR burst per command.
// Optional perf counters are built only when DRAM_WRITE_PERF_EN is defined.
module dram_write_engine #(
  parameter int DATA_DEPTH = 1024,
  parameter int CTRL_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [35:0] data_in,
  input  logic        data_we,
  input  logic [39:0] ctrl_in,
  input  logic        ctrl_we,
  output logic        data_full,
  output logic        ctrl_full,
  output logic        busy,
  output logic        ovf,
  output logic        err,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] perf_bursts,
  output logic [31:0] perf_stall
);
  // state | meaning
  // IDLE  | waiting for a command whose data is fully buffered
  // AW    | address phase of the latched command
  // W     | streaming len_r beats from the data FIFO
  // B     | waiting for the write response
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CAW = $clog2(CTRL_DEPTH);
  localparam logic [DAW:0] D_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [CAW:0] C_FULL = (CAW+1)'(CTRL_DEPTH);
  localparam logic [DAW:0] D_ONE  = (DAW+1)'(1);
  localparam logic [CAW:0] C_ONE  = (CAW+1)'(1);

  logic [35:0]    d_mem [DATA_DEPTH];
  logic [DAW-1:0] d_wp, d_rp;
  logic [DAW:0]   d_cnt, d_cnt_nxt;
  logic [39:0]    c_mem [CTRL_DEPTH];
  logic [CAW-1:0] c_wp, c_rp;
  logic [CAW:0]   c_cnt, c_cnt_nxt;

  logic        d_push, d_pop, c_push, c_pop;
  logic [35:0] d_head;
  logic [39:0] c_head;
  logic [7:0]  head_len;
  logic        unused_addr_lsb;

  state_t      state;
  logic [7:0]  len_r, beat_cnt;
  logic [29:0] addr_r;

  assign d_head   = d_mem[d_rp];
  assign c_head   = c_mem[c_rp];
  assign head_len = c_head[39:32];
  assign unused_addr_lsb = ^c_head[1:0];

  // A command leaves the FIFO only once its whole burst is buffered, so W never stalls on data.
  assign d_pop  = m_axi_wvalid & m_axi_wready;
  assign c_pop  = (state == IDLE) && (c_cnt != '0) &&
                  ((head_len == 8'd0) || (d_cnt >= {{(DAW+1-8){1'b0}}, head_len}));
  assign d_push = data_we & ((d_cnt != D_FULL) | d_pop);
  assign c_push = ctrl_we & ((c_cnt != C_FULL) | c_pop);

  always_comb begin
    d_cnt_nxt = d_cnt;
    if (d_push && !d_pop) d_cnt_nxt = d_cnt + D_ONE;
    else if (!d_push && d_pop) d_cnt_nxt = d_cnt - D_ONE;
    c_cnt_nxt = c_cnt;
    if (c_push && !c_pop) c_cnt_nxt = c_cnt + C_ONE;
    else if (!c_push && c_pop) c_cnt_nxt = c_cnt - C_ONE;
  end

  always_ff @(posedge CLK) begin
    if (d_push) d_mem[d_wp] <= data_in;
    if (c_push) c_mem[c_wp] <= ctrl_in;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_wp      <= '0;
      d_rp      <= '0;
      d_cnt     <= '0;
      data_full <= 1'b0;
      c_wp      <= '0;
      c_rp      <= '0;
      c_cnt     <= '0;
      ctrl_full <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (d_push) d_wp <= d_wp + DAW'(1);
      if (d_pop)  d_rp <= d_rp + DAW'(1);
      if (c_push) c_wp <= c_wp + CAW'(1);
      if (c_pop)  c_rp <= c_rp + CAW'(1);
      d_cnt     <= d_cnt_nxt;
      c_cnt     <= c_cnt_nxt;
      data_full <= (d_cnt_nxt == D_FULL);
      ctrl_full <= (c_cnt_nxt == C_FULL);
      if ((data_we && !d_push) || (ctrl_we && !c_push)) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      len_r         <= '0;
      addr_r        <= '0;
      beat_cnt      <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (c_pop && head_len != 8'd0) begin
          len_r         <= head_len;
          addr_r        <= c_head[31:2];
          m_axi_awvalid <= 1'b1;
          busy          <= 1'b1;
          state         <= AW;
        end
        AW: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b1;
          beat_cnt      <= len_r;
          state         <= W;
        end
        W: if (m_axi_wready) begin
          beat_cnt <= beat_cnt - 8'd1;
          if (beat_cnt == 8'd1) begin
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b1;
            state        <= B;
          end
        end
        B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          busy         <= 1'b0;
          if (m_axi_bresp != 2'b00) err <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi_awaddr  = {addr_r, 2'b00};
  assign m_axi_awlen   = len_r - 8'd1;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = d_head[31:0];
  assign m_axi_wstrb   = d_head[35:32];
  assign m_axi_wlast   = m_axi_wvalid & (beat_cnt == 8'd1);

`ifdef DRAM_WRITE_PERF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_bursts <= '0;
      perf_stall  <= '0;
    end else begin
      if (m_axi_bvalid && m_axi_bready && perf_bursts != '1)
        perf_bursts <= perf_bursts + 32'd1;
      if (((m_axi_awvalid && !m_axi_awready) || (m_axi_wvalid && !m_axi_wready)) &&
          perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_bursts = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_dram_write_engine.sv
// Testbench for dram_write_engine: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours DRAM_WRITE_PERF_EN.
module tb_dram_write_engine;
  localparam int DATA_DEPTH = 1024;
  localparam int CTRL_DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we;
  logic        data_full, ctrl_full, busy, ovf, err;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] perf_bursts, perf_stall;

  dram_write_engine #(.DATA_DEPTH(DATA_DEPTH), .CTRL_DEPTH(CTRL_DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
    .data_full(data_full), .ctrl_full(ctrl_full), .busy(busy), .ovf(ovf), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .perf_bursts(perf_bursts), .perf_stall(perf_stall)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what has been accepted but not yet written, plus the burst in flight.
  logic [35:0] dq[$];
  logic [39:0] cq[$];
  bit          awp, bp, m_ovf, m_err;
  int          beats;
  logic [7:0]  cur_len;
  logic [31:0] cur_addr;
  int unsigned m_bursts, m_stall;

  // Observed traffic, for the directed checks.
  int          aw_cnt = 0, w_cnt = 0, burst_beat = 0, wlast_at = 0;
  logic [31:0] last_awaddr, last_wdata;
  logic [7:0]  last_awlen;

  // Bus responder controls: 0 = always ready, 1 = random, 2 = driven by the stimulus.
  int mode    = 0;
  int bad_idx = -1;
  int b_count = 0;
  bit b_hs_next = 1'b0;

  task automatic check_outputs();
    logic [63:0] exp_bursts, exp_stall;
`ifdef DRAM_WRITE_PERF_EN
    exp_bursts = 64'(m_bursts);
    exp_stall  = 64'(m_stall);
`else
    exp_bursts = 64'd0;
    exp_stall  = 64'd0;
`endif
    chk("awvalid", 64'(m_axi_awvalid), 64'(awp));
    chk("wvalid", 64'(m_axi_wvalid), 64'(beats != 0));
    chk("wlast", 64'(m_axi_wlast), 64'(beats == 1));
    chk("bready", 64'(m_axi_bready), 64'(bp));
    chk("busy", 64'(busy), 64'(awp || bp || beats != 0));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("err", 64'(err), 64'(m_err));
    chk("data_full", 64'(data_full), 64'(dq.size() == DATA_DEPTH));
    chk("ctrl_full", 64'(ctrl_full), 64'(cq.size() == CTRL_DEPTH));
    chk("perf_bursts", 64'(perf_bursts), exp_bursts);
    chk("perf_stall", 64'(perf_stall), exp_stall);
    if (awp) begin
      chk("awaddr", 64'(m_axi_awaddr), 64'(cur_addr & 32'hFFFF_FFFC));
      chk("awlen", 64'(m_axi_awlen), 64'(8'(cur_len - 8'd1)));
      chk("awsize", 64'(m_axi_awsize), 64'd2);
      chk("awburst", 64'(m_axi_awburst), 64'd1);
    end
    if (beats != 0) begin
      chk("wdata", 64'(m_axi_wdata), 64'(dq[0][31:0]));
      chk("wstrb", 64'(m_axi_wstrb), 64'(dq[0][35:32]));
    end
  endtask

  // Advance the model across the coming rising edge, from the inputs as they stand now.
  task automatic model_step();
    bit was_idle, aw_hs, w_hs, b_hs, cpop;
    int dsz, csz;
    was_idle = !awp && !bp && beats == 0;
    aw_hs = awp && m_axi_awready;
    w_hs  = beats != 0 && m_axi_wready;
    b_hs  = bp && m_axi_bvalid;
    dsz = dq.size();
    csz = cq.size();
    if ((awp && !m_axi_awready) || (beats != 0 && !m_axi_wready)) m_stall++;
    cpop = 1'b0;
    if (was_idle && csz > 0) begin
      if (cq[0][39:32] == 8'd0) cpop = 1'b1;
      else if (dsz >= int'(cq[0][39:32])) begin
        cpop = 1'b1;
        awp = 1'b1;
        cur_len = cq[0][39:32];
        cur_addr = cq[0][31:0];
      end
    end
    if (cpop) void'(cq.pop_front());
    if (aw_hs) begin
      awp = 1'b0;
      beats = int'(cur_len);
    end
    if (w_hs) begin
      void'(dq.pop_front());
      beats--;
      if (beats == 0) bp = 1'b1;
    end
    if (b_hs) begin
      bp = 1'b0;
      m_bursts++;
      if (m_axi_bresp != 2'b00) m_err = 1'b1;
    end
    if (data_we) begin
      if (dsz < DATA_DEPTH || w_hs) dq.push_back(data_in);
      else m_ovf = 1'b1;
    end
    if (ctrl_we) begin
      if (csz < CTRL_DEPTH || cpop) cq.push_back(ctrl_in);
      else m_ovf = 1'b1;
    end
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      dq.delete();
      cq.delete();
      awp = 1'b0; bp = 1'b0; beats = 0;
      m_ovf = 1'b0; m_err = 1'b0; m_bursts = 0; m_stall = 0;
    end
    check_outputs();
    b_hs_next = m_axi_bvalid && m_axi_bready;
    if (RST_N) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_cnt++;
        last_awaddr = m_axi_awaddr;
        last_awlen  = m_axi_awlen;
        burst_beat  = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_cnt++;
        burst_beat++;
        last_wdata = m_axi_wdata;
        if (m_axi_wlast) wlast_at = burst_beat;
      end
      model_step();
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!RST_N) begin
      m_axi_bvalid = 1'b0;
      b_count = 0;
    end else begin
      if (b_hs_next) begin
        m_axi_bvalid = 1'b0;
        b_count++;
      end
      if (!m_axi_bvalid && m_axi_bready && (mode != 1 || $urandom_range(0, 1) == 1)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_count == bad_idx) ? 2'b10 : 2'b00;
      end
    end
    if (mode == 0) begin
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
    end else if (mode == 1) begin
      m_axi_awready = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_data(input logic [35:0] d);
    data_in = d;
    data_we = 1'b1;
    tick(1);
    data_we = 1'b0;
  endtask

  task automatic push_ctrl(input logic [39:0] c);
    ctrl_in = c;
    ctrl_we = 1'b1;
    tick(1);
    ctrl_we = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((awp || bp || beats != 0 || cq.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    n_assert++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, aw0, n;
    RST_N = 1'b0;
    data_we = 1'b0; ctrl_we = 1'b0; data_in = '0; ctrl_in = '0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    tick(3);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf", 64'({perf_bursts, perf_stall}), 64'd0);
    RST_N = 1'b1;
    tick(1);

    // Basic burst: 64 beats of 0..63 then the command.
    for (int i = 0; i < 64; i++) push_data({4'hF, 32'(i)});
    push_ctrl({8'd64, 32'h0100_0000});
    wait_idle("basic", 500);
    chk("basic_awaddr", 64'(last_awaddr), 64'h0100_0000);
    chk("basic_awlen", 64'(last_awlen), 64'd63);
    chk("basic_beats", 64'(w_cnt), 64'd64);
    chk("basic_wlast_beat", 64'(wlast_at), 64'd64);
    chk("basic_last_data", 64'(last_wdata), 64'd63);
    tick(1);
    chk("basic_busy_low", 64'(busy), 64'd0);

    // Command ahead of its data: nothing until the 64th beat lands.
    push_ctrl({8'd64, 32'h0100_1000});
    for (int i = 0; i < 63; i++) push_data({4'h3, 32'h1000 + 32'(i)});
    tick(3);
    chk("early_cmd_no_aw", 64'(m_axi_awvalid), 64'd0);
    data_in = {4'h3, 32'h1000 + 32'd63};
    data_we = 1'b1;
    tick(1);
    data_we = 1'b0;
    chk("aw_not_yet", 64'(m_axi_awvalid), 64'd0);
    tick(1);
    chk("aw_two_later", 64'(m_axi_awvalid), 64'd1);
    wait_idle("early_cmd", 500);

    // Randomly throttled line of 25 x 64 beats.
    base = w_cnt;
    mode = 1;
    for (int k = 0; k < 25; k++) begin
      n = 0;
      while (dq.size() > DATA_DEPTH - 64 && n < 5000) begin tick(1); n++; end
      for (int i = 0; i < 64; i++) begin
        push_data({4'($urandom), 32'($urandom)});
        if ($urandom_range(0, 3) == 0) tick(1);
      end
      n = 0;
      while (cq.size() >= CTRL_DEPTH && n < 5000) begin tick(1); n++; end
      push_ctrl({8'd64, 32'h0200_0000 + 32'(k * 256)});
    end
    wait_idle("random_line", 20000);
    mode = 0;
    tick(2);
    chk("random_beats", 64'(w_cnt - base), 64'd1600);
    chk("random_no_ovf", 64'(ovf), 64'd0);

    // Overflow on a full data FIFO: extra word dropped.
    do_reset();
    for (int i = 0; i < DATA_DEPTH; i++) push_data({4'hF, 32'hA000_0000 + 32'(i)});
    chk("fill_full", 64'(data_full), 64'd1);
    push_data({4'hF, 32'hDEAD_BEEF});
    chk("ovf_set", 64'(ovf), 64'd1);
    for (int i = 0; i < 4; i++) push_ctrl({8'd255, 32'h0300_0000 + 32'(i * 1024)});
    push_ctrl({8'd4, 32'h0300_1000});
    wait_idle("ovf_drain", 3000);
    chk("ovf_contents", 64'(last_wdata), 64'hA000_03FF);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Push on a full FIFO in the same cycle as a pop: accepted, no overflow.
    do_reset();
    mode = 2;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b0;
    for (int i = 0; i < DATA_DEPTH; i++) push_data({4'hF, 32'hB000_0000 + 32'(i)});
    push_ctrl({8'd64, 32'h0400_0000});
    n = 0;
    while (!m_axi_wvalid && n < 50) begin tick(1); n++; end
    chk("simul_wvalid", 64'(m_axi_wvalid), 64'd1);
    chk("simul_full_before", 64'(data_full), 64'd1);
    data_in = {4'hF, 32'hCAFE_0000};
    data_we = 1'b1;
    m_axi_wready = 1'b1;
    tick(1);
    data_we = 1'b0;
    m_axi_wready = 1'b0;
    chk("simul_ovf_clear", 64'(ovf), 64'd0);
    chk("simul_full_after", 64'(data_full), 64'd1);
    mode = 0;
    for (int i = 0; i < 3; i++) push_ctrl({8'd255, 32'h0400_1000 + 32'(i * 1024)});
    push_ctrl({8'd196, 32'h0400_2000});
    wait_idle("simul_drain", 3000);
    chk("simul_last_word", 64'(last_wdata), 64'hCAFE_0000);

    // Error response on the second of three bursts.
    do_reset();
    aw0 = aw_cnt;
    bad_idx = 1;
    for (int i = 0; i < 12; i++) push_data({4'h5, 32'hC000_0000 + 32'(i)});
    for (int i = 0; i < 3; i++) push_ctrl({8'd4, 32'h0500_0000 + 32'(i * 16)});
    wait_idle("bresp", 500);
    bad_idx = -1;
    chk("bresp_err", 64'(err), 64'd1);
    chk("bresp_three_aw", 64'(aw_cnt - aw0), 64'd3);
    chk("bresp_last_addr", 64'(last_awaddr), 64'h0500_0020);
`ifdef DRAM_WRITE_PERF_EN
    chk("bresp_perf_bursts", 64'(perf_bursts), 64'd3);
`endif

    // Reset during beat 10 of a burst, then recovery.
    base = w_cnt;
    for (int i = 0; i < 64; i++) push_data({4'hF, 32'hD000_0000 + 32'(i)});
    push_ctrl({8'd64, 32'h0600_0000});
    n = 0;
    while (w_cnt < base + 10 && n < 500) begin tick(1); n++; end
    chk("midrst_beat", 64'(m_axi_wdata), 64'hD000_000A);
    RST_N = 1'b0;
    #1;
    chk("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("midrst_wlast", 64'(m_axi_wlast), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_perf", 64'({perf_bursts, perf_stall}), 64'd0);
    chk("midrst_data_full", 64'(data_full), 64'd0);
    tick(2);
    RST_N = 1'b1;
    tick(1);
    aw0 = aw_cnt;
    push_ctrl({8'd0, 32'h0700_0000});
    tick(5);
    chk("len0_no_aw", 64'(aw_cnt - aw0), 64'd0);
    for (int i = 0; i < 8; i++) push_data({4'h9, 32'hE000_0000 + 32'(i)});
    push_ctrl({8'd8, 32'h0700_0103});
    wait_idle("after_rst", 500);
    chk("after_rst_aw", 64'(aw_cnt - aw0), 64'd1);
    chk("after_rst_awlen", 64'(last_awlen), 64'd7);
    chk("after_rst_awaddr", 64'(last_awaddr), 64'h0700_0100);
    chk("after_rst_wlast", 64'(wlast_at), 64'd8);
    chk("after_rst_data", 64'(last_wdata), 64'hE000_0007);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
